// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between scalar single-beat accesses and locked vector bursts,
// with vector starvation protection and routing of read returns to the requester that issued them.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_s_req,
    input  logic          i_s_we,
    input  logic [AW-1:0] i_s_addr,
    input  logic [DW-1:0] i_s_wdata,
    output logic          o_s_gnt,
    output logic          o_s_stall,
    output logic          o_s_rvalid,
    input  logic          i_v_req,
    input  logic          i_v_we,
    input  logic [AW-1:0] i_v_addr,
    input  logic [DW-1:0] i_v_wdata,
    input  logic          i_v_last,
    output logic          o_v_gnt,
    output logic          o_v_rvalid,
    output logic [DW-1:0] o_rdata,
    output logic          o_busy,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ready,
    input  logic [DW-1:0] i_mem_rdata
);
    typedef enum logic {IDLE, VLOCK} state_t;
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_owner_q, rd_owner_d;
    logic          v_sel, s_sel, accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        // once locked, scalar is shut out until the burst's last beat is accepted
        v_sel       = (state_q == VLOCK) ? i_v_req : i_v_req && (!i_s_req || starve_q == LIM);
        s_sel       = (state_q == IDLE) && !v_sel && i_s_req;
        o_mem_en    = v_sel || s_sel;
        o_mem_we    = v_sel ? i_v_we : s_sel ? i_s_we : 1'b0;
        o_mem_addr  = v_sel ? i_v_addr : s_sel ? i_s_addr : '0;
        o_mem_wdata = v_sel ? i_v_wdata : s_sel ? i_s_wdata : '0;
        accept      = o_mem_en && i_mem_ready;
        o_v_gnt     = v_sel && i_mem_ready;
        o_s_gnt     = s_sel && i_mem_ready;
        o_s_stall   = i_s_req && !o_s_gnt;
        state_d     = (state_q == IDLE) ? ((o_v_gnt && !i_v_last) ? VLOCK : IDLE)
                                        : ((o_v_gnt && i_v_last) ? IDLE : VLOCK);
        starve_d    = o_v_gnt ? '0
                    : ((state_q == IDLE) && i_v_req && starve_q != LIM) ? starve_q + CW'(1)
                    : starve_q;
        rd_pend_d   = accept && !o_mem_we;
        rd_owner_d  = rd_pend_d ? v_sel : rd_owner_q;
        o_s_rvalid  = rd_pend_q && !rd_owner_q;
        o_v_rvalid  = rd_pend_q && rd_owner_q;
        o_busy      = state_q == VLOCK;
        o_rdata     = i_mem_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: cycle-by-cycle directed vectors for dmem_arbiter plus a reset-mid-burst sequence.
module tb_dmem_arbiter;
    logic        clk = 1'b0, rst = 1'b0;
    logic        s_req, s_we, v_req, v_we, v_last, rdy;
    logic [31:0] s_addr, s_wd, v_addr, v_wd, rdata;
    logic        s_gnt, s_stall, s_rvalid, v_gnt, v_rvalid, busy, mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, o_rdata;
    logic [7:0]  flags;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .CW(3)) dut (
        .clk(clk), .rst(rst),
        .i_s_req(s_req), .i_s_we(s_we), .i_s_addr(s_addr), .i_s_wdata(s_wd),
        .o_s_gnt(s_gnt), .o_s_stall(s_stall), .o_s_rvalid(s_rvalid),
        .i_v_req(v_req), .i_v_we(v_we), .i_v_addr(v_addr), .i_v_wdata(v_wd), .i_v_last(v_last),
        .o_v_gnt(v_gnt), .o_v_rvalid(v_rvalid), .o_rdata(o_rdata), .o_busy(busy),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(rdy), .i_mem_rdata(rdata)
    );

    // {s_gnt, s_stall, s_rvalid, v_gnt, v_rvalid, busy, mem_en, mem_we}
    assign flags = {s_gnt, s_stall, s_rvalid, v_gnt, v_rvalid, busy, mem_en, mem_we};

    typedef struct {
        logic        s_req, s_we, v_req, v_we, v_last, rdy;
        logic [31:0] s_addr, s_wd, v_addr, v_wd, rdata;
        logic [7:0]  ef;
        logic [31:0] ea, ew;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int sr, int sw, logic [31:0] sa, logic [31:0] sd,
                                int vr, int vw, logic [31:0] va, logic [31:0] vd, int vl,
                                int rd, logic [31:0] rdat, logic [7:0] ef, logic [31:0] ea, logic [31:0] ew);
        vec_t r;
        r.s_req = sr[0]; r.s_we = sw[0]; r.s_addr = sa; r.s_wd = sd;
        r.v_req = vr[0]; r.v_we = vw[0]; r.v_addr = va; r.v_wd = vd; r.v_last = vl[0];
        r.rdy = rd[0]; r.rdata = rdat; r.ef = ef; r.ea = ea; r.ew = ew;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        s_req = r.s_req; s_we = r.s_we; s_addr = r.s_addr; s_wd = r.s_wd;
        v_req = r.v_req; v_we = r.v_we; v_addr = r.v_addr; v_wd = r.v_wd; v_last = r.v_last;
        rdy = r.rdy; rdata = r.rdata;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0, 0,0,0,0,0, 1,0, 8'h00,0,0);
        // scalar read, then its return
        tbl.push_back(mk(1,0,'h100,0, 0,0,0,0,0, 1,0,           8'b1000_0010,'h100,0));
        tbl.push_back(mk(0,0,0,0,     0,0,0,0,0, 1,'hDEADBEEF,  8'b0010_0000,0,0));
        // simultaneous first requests: scalar wins, vector single-beat follows
        tbl.push_back(mk(1,0,'h104,0, 1,0,'h300,0,1, 1,0,       8'b1000_0010,'h104,0));
        tbl.push_back(mk(0,0,0,0,     1,0,'h300,0,1, 1,'h1111,  8'b0011_0010,'h300,0));
        tbl.push_back(mk(0,0,0,0,     0,0,0,0,0,     1,'h2222,  8'b0000_1000,0,0));
        // continuous contention: four scalar writes, then vector forced through
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,1,'h40,'h11, 1,0,'h500,'h77,1, 1,0, 8'b1000_0011,'h40,'h11));
        tbl.push_back(mk(1,1,'h40,'h11, 1,0,'h500,'h77,1, 1,0,   8'b0101_0010,'h500,'h77));
        tbl.push_back(mk(1,1,'h40,'h11, 0,0,0,0,0, 1,'h3333,     8'b1000_1011,'h40,'h11));
        // 4-beat vector read burst with scalar arriving at beat 2
        tbl.push_back(mk(0,0,0,0,     1,0,'h200,0,0, 1,0,       8'b0001_0010,'h200,0));
        tbl.push_back(mk(1,0,'h104,0, 1,0,'h204,0,0, 1,'hB0,    8'b0101_1110,'h204,0));
        tbl.push_back(mk(1,0,'h104,0, 1,0,'h208,0,0, 1,'hB1,    8'b0101_1110,'h208,0));
        tbl.push_back(mk(1,0,'h104,0, 1,0,'h20C,0,1, 1,'hB2,    8'b0101_1110,'h20C,0));
        tbl.push_back(mk(1,0,'h104,0, 0,0,0,0,0,     1,'hB3,    8'b1000_1010,'h104,0));
        tbl.push_back(mk(0,0,0,0,     0,0,0,0,0,     1,'hC0,    8'b0010_0000,0,0));
        // vector write burst under back-pressure, with an idle gap inside the lock
        tbl.push_back(mk(0,0,0,0,     1,1,'h600,'hA0,0, 1,0,    8'b0001_0011,'h600,'hA0));
        tbl.push_back(mk(0,0,0,0,     1,1,'h604,'hA1,0, 0,0,    8'b0000_0111,'h604,'hA1));
        tbl.push_back(mk(0,0,0,0,     1,1,'h604,'hA1,0, 1,0,    8'b0001_0111,'h604,'hA1));
        tbl.push_back(mk(1,0,'h104,0, 0,0,0,0,0,        1,0,    8'b0100_0100,0,0));
        tbl.push_back(mk(0,0,0,0,     1,1,'h608,'hA2,1, 0,0,    8'b0000_0111,'h608,'hA2));
        tbl.push_back(mk(0,0,0,0,     1,1,'h608,'hA2,1, 1,0,    8'b0001_0111,'h608,'hA2));
        tbl.push_back(mk(0,0,0,0,     0,0,0,0,0,        1,0,    8'b0000_0000,0,0));
        // scalar back-pressure in IDLE
        tbl.push_back(mk(1,0,'h104,0, 0,0,0,0,0, 0,0,           8'b0100_0010,'h104,0));
        tbl.push_back(mk(1,0,'h104,0, 0,0,0,0,0, 1,0,           8'b1000_0010,'h104,0));
        tbl.push_back(mk(0,0,0,0,     0,0,0,0,0, 1,'hD0,        8'b0010_0000,0,0));

        drive(idle);
        #12;
        chk("reset_flags", {24'h0, flags}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d_flags", i), {24'h0, flags}, {24'h0, tbl[i].ef});
            chk($sformatf("row%0d_addr", i), mem_addr, tbl[i].ea);
            chk($sformatf("row%0d_wdata", i), mem_wdata, tbl[i].ew);
            if (tbl[i].ef[5] || tbl[i].ef[3])
                chk($sformatf("row%0d_rdata", i), o_rdata, tbl[i].rdata);
        end

        // reset during beat 3 of a read burst with beat 2's return pending
        @(negedge clk);
        drive(mk(0,0,0,0, 1,0,'h700,0,0, 1,0, 0,0,0));
        #1 chk("rst_beat1_gnt", {31'h0, v_gnt}, 32'h1);
        @(negedge clk);
        drive(mk(0,0,0,0, 1,0,'h704,0,0, 1,0, 0,0,0));
        #1 chk("rst_beat2_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        drive(mk(0,0,0,0, 1,0,'h708,0,0, 1,0, 0,0,0));
        #1 chk("rst_pre_vrvalid", {31'h0, v_rvalid}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_vrvalid", {31'h0, v_rvalid}, 32'h0);
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        @(negedge clk);
        drive(mk(1,0,'h104,0, 0,0,0,0,0, 1,0, 0,0,0));
        #1;
        chk("post_rst_sgnt", {31'h0, s_gnt}, 32'h1);
        chk("post_rst_stall", {31'h0, s_stall}, 32'h0);
        chk("post_rst_addr", mem_addr, 32'h104);
        @(negedge clk);
        drive(idle);
        #1 chk("post_rst_srvalid", {31'h0, s_rvalid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the scalar pipeline memory-access stage and the vector load/store unit.
- Scalar accesses are single-beat. Vector accesses are bursts, and the port stays locked to the vector unit until the burst's last beat is accepted.
- Provides a scalar stall output, starvation protection for the vector unit, and routing of returned read data to the correct requester.
- Sits between the core's memory-stage signals and the external data-memory interface, replacing the static vector/scalar mux.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 4, consecutive cycles a waiting vector request may lose to scalar before it is forced through
CW, 3, starvation counter width; must satisfy 2^CW-1 >= STARVE_LIMIT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
i_s_req  in  1  scalar access request, held until granted
i_s_we  in  1  scalar write (1) / read (0)
i_s_addr  in  AW  scalar address
i_s_wdata  in  DW  scalar write data
o_s_gnt  out  1  scalar beat accepted this cycle
o_s_stall  out  1  i_s_req && !o_s_gnt; feeds pipeline stall
o_s_rvalid  out  1  scalar read data valid
i_v_req  in  1  vector beat request
i_v_we  in  1  vector write / read
i_v_addr  in  AW  vector beat address
i_v_wdata  in  DW  vector write data
i_v_last  in  1  final beat of burst, qualified by i_v_req
o_v_gnt  out  1  vector beat accepted this cycle
o_v_rvalid  out  1  vector read data valid
o_rdata  out  DW  read data to both requesters (= i_mem_rdata)
o_busy  out  1  arbiter locked to vector burst
o_mem_en  out  1  memory access request
o_mem_we  out  1  memory write enable
o_mem_addr  out  AW  memory address
o_mem_wdata  out  DW  memory write data
i_mem_ready  in  1  memory accepts access this cycle
i_mem_rdata  in  DW  read data, valid 1 cycle after accepted read

Behaviour:
- States: IDLE, VLOCK. Reset (rst=0, async): state=IDLE, starve_cnt=0, rd_pend=0, rd_owner=0. o_s_rvalid=o_v_rvalid=0 and o_busy=0 at reset; all other outputs are combinational from inputs and state.
- Selection in IDLE:
  - Vector is selected if i_v_req && (!i_s_req || starve_cnt==STARVE_LIMIT).
  - Otherwise scalar is selected if i_s_req.
  - Otherwise nothing is selected: o_mem_en=0.
- Selection in VLOCK: vector only. Scalar is never selected, and o_mem_en=i_v_req. If i_v_req drops, the port idles and the lock holds.
- Memory outputs: o_mem_en/we/addr/wdata are the combinational mux of the selected requester. When nothing is selected, addr/wdata=0 and we=0.
- Accept: a selected beat is accepted when o_mem_en && i_mem_ready. o_s_gnt / o_v_gnt equal accept for the selected requester, so they are combinational in i_mem_ready.
- Transitions:
  - IDLE→VLOCK on an accepted vector beat with !i_v_last.
  - VLOCK→IDLE on an accepted vector beat with i_v_last.
  - A single-beat vector access (last on the first beat) stays in IDLE.
- o_busy = (state==VLOCK).
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle in IDLE with i_v_req && !o_v_gnt.
  - Clears on any accepted vector beat.
  - Holds in VLOCK.
- Read return:
  - On an accepted read: rd_pend<=1, rd_owner<=selected requester.
  - Otherwise rd_pend<=0.
  - o_s_rvalid = rd_pend && owner==scalar; o_v_rvalid = rd_pend && owner==vector.
  - Read latency from accept to rvalid is exactly 1 cycle. Back-to-back reads are supported, one return per cycle.
- Writes produce no rvalid.
- Back-pressure: with i_mem_ready=0, the selection is recomputed each cycle. A scalar request waiting in IDLE may lose to vector once starvation triggers. Requesters must hold their signals until their gnt.
- Reset mid-burst: returns to IDLE immediately; a pending rvalid is dropped.

Test Plan:
- Scalar-only read addr 0x100, i_mem_ready=1, i_mem_rdata=0xDEADBEEF next cycle -> o_s_gnt=1 in cycle 0, o_s_rvalid=1 with o_rdata=0xDEADBEEF in cycle 1, o_v_rvalid=0.
- Vector 4-beat read burst at 0x200..0x20C; scalar requests at beat 2 -> o_busy=1 from beat 1 through beat 3 accept, o_s_stall=1 throughout, scalar granted the cycle after beat 4 (last), four o_v_rvalid pulses.
- Both requesting continuously in IDLE, STARVE_LIMIT=4 -> scalar granted 4 cycles, vector single-beat (last=1) granted 5th cycle, starve_cnt returns to 0, scalar resumes.
- Vector write burst with i_mem_ready toggling 1,0,1,0 -> o_v_gnt only in ready cycles, o_mem_addr held stable, no rvalid, lock released only on accepted last beat.
- Reset asserted (rst=0) during VLOCK beat 2 of 4 with read pending -> next cycle state IDLE, o_busy=0, o_v_rvalid=0; after release a scalar request is granted immediately.
- Simultaneous first requests, starve_cnt=0 -> scalar wins, o_v_gnt=0, starve_cnt=1 next cycle.
